// File: rtl/agusec_check_pipe.sv
// agusec_check_pipe: two-stage per-lane bounded-pointer check with an optional sticky fault log.
// Define AGUSEC_FAULT_LOG_EN to build fault capture and counting; otherwise the fault outputs are tied to 0.
module agusec_check_pipe #(
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic [CHANNELS-1:0]    in_valid,
    input  logic [64*CHANNELS-1:0] in_ptr,
    input  logic [40*CHANNELS-1:0] in_a,
    input  logic [40*CHANNELS-1:0] in_b,
    input  logic [CHANNELS-1:0]    in_secq,
    output logic [CHANNELS-1:0]    out_valid,
    output logic [CHANNELS-1:0]    out_ok,
    output logic                   fault_valid,
    output logic [2:0]             fault_lane,
    output logic [63:0]            fault_ptr,
    output logic [CNT_W-1:0]       fault_cnt,
    input  logic                   fault_clr
);
    logic [64*CHANNELS-1:0] ptr_out;
    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        logic [63:0] ptr;
        logic [43:0] eaddr;
        logic [7:0]  bits_d, bits_q;
        logic [6:0]  hi_q, lo_q;
        logic        v1_q, sec_q, onl_q, e31_q, ov_q, ok_q, diff, ok_d;
        assign ptr    = in_ptr[g*64 +: 64];
        assign eaddr  = ptr[43:0] + 44'(in_a[g*40 +: 40]) + 44'(in_b[g*40 +: 40]);
        assign bits_d = 8'({8'd0, eaddr} >> (6'(ptr[63:59]) + 6'd4));
        assign diff   = hi_q >= lo_q;
        // exp==31 marks an unbounded pointer: only the incoming security bit matters
        assign ok_d   = sec_q && (e31_q || ((bits_q >= {lo_q, 1'b0} || (diff && !onl_q)) &&
                                            (bits_q <= {hi_q, 1'b1} || (diff && onl_q))));
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v1_q   <= 1'b0;
                sec_q  <= 1'b0;
                onl_q  <= 1'b0;
                e31_q  <= 1'b0;
                bits_q <= '0;
                hi_q   <= '0;
                lo_q   <= '0;
                ov_q   <= 1'b0;
                ok_q   <= 1'b0;
            end else if (!stall) begin
                v1_q   <= in_valid[g];
                sec_q  <= in_secq[g];
                onl_q  <= ptr[44];
                e31_q  <= &ptr[63:59];
                bits_q <= bits_d;
                hi_q   <= ptr[58:52];
                lo_q   <= ptr[51:45];
                ov_q   <= v1_q;
                ok_q   <= v1_q && ok_d;
            end
        end
        assign out_valid[g] = ov_q;
        assign out_ok[g]    = ok_q;
`ifdef AGUSEC_FAULT_LOG_EN
        logic [63:0] ptr1_q, ptr2_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ptr1_q <= '0;
                ptr2_q <= '0;
            end else if (!stall) begin
                ptr1_q <= ptr;
                ptr2_q <= ptr1_q;
            end
        end
        assign ptr_out[g*64 +: 64] = ptr2_q;
`else
        assign ptr_out[g*64 +: 64] = '0;
`endif
    end

`ifdef AGUSEC_FAULT_LOG_EN
    logic [CHANNELS-1:0] flt;
    logic [3:0]          nf;
    logic [CNT_W-1:0]    base, cnt_q;
    logic [CNT_W:0]      sum;
    logic [2:0]          lane_d, lane_q;
    logic [63:0]         fptr_d, fptr_q;
    logic                fv_q;
    assign flt  = out_valid & ~out_ok;
    assign base = fault_clr ? '0 : cnt_q;
    always_comb begin
        nf     = '0;
        lane_d = lane_q;
        fptr_d = fptr_q;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            nf = nf + 4'(flt[i]);
            if (flt[i] && (!fv_q || fault_clr)) begin
                lane_d = 3'(i);
                fptr_d = ptr_out[i*64 +: 64];
            end
        end
        sum = {1'b0, base} + (CNT_W+1)'(nf);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fv_q   <= 1'b0;
            lane_q <= '0;
            fptr_q <= '0;
            cnt_q  <= '0;
        end else if (!stall) begin
            fv_q   <= (fv_q && !fault_clr) || |flt;
            lane_q <= lane_d;
            fptr_q <= fptr_d;
            cnt_q  <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        end
    end
    assign fault_valid = fv_q;
    assign fault_lane  = lane_q;
    assign fault_ptr   = fptr_q;
    assign fault_cnt   = cnt_q;
`else
    logic unused_fault;
    assign unused_fault = fault_clr ^ (^ptr_out);
    assign fault_valid  = 1'b0;
    assign fault_lane   = '0;
    assign fault_ptr    = '0;
    assign fault_cnt    = '0;
`endif
endmodule

// File: tb/tb_agusec_check_pipe.sv
// tb_agusec_check_pipe: vector table, hand sequences and randomized traffic against a transaction-level model.
module tb_agusec_check_pipe;
    localparam int CH = 2;
    localparam int CW = 4;
    logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0, fault_clr = 1'b0;
    logic [CH-1:0] in_valid = '0, in_secq = '0, out_valid, out_ok;
    logic [64*CH-1:0] in_ptr = '0;
    logic [40*CH-1:0] in_a = '0, in_b = '0;
    logic fault_valid;
    logic [2:0] fault_lane;
    logic [63:0] fault_ptr;
    logic [CW-1:0] fault_cnt;
    int n_cmp = 0, n_err = 0;

    agusec_check_pipe #(.CHANNELS(CH), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .in_valid(in_valid), .in_ptr(in_ptr),
        .in_a(in_a), .in_b(in_b), .in_secq(in_secq), .out_valid(out_valid), .out_ok(out_ok),
        .fault_valid(fault_valid), .fault_lane(fault_lane), .fault_ptr(fault_ptr),
        .fault_cnt(fault_cnt), .fault_clr(fault_clr)
    );

    always #5 clk = ~clk;

    typedef struct { bit v; bit ok; logic [63:0] ptr; } res_t;
    typedef struct { logic [63:0] ptr; logic [39:0] a; logic [39:0] b; bit sq; bit ok; } vec_t;
    res_t p1[CH], p2[CH];
    bit m_fv;
    int m_lane, m_cnt;
    logic [63:0] m_fptr;

    function automatic logic [63:0] mk(int e, int hi, int lo, bit onl, logic [43:0] ad);
        return {5'(e), 7'(hi), 7'(lo), onl, ad};
    endfunction

    function automatic bit ref_ok(logic [63:0] p, logic [39:0] a, logic [39:0] b, bit sq);
        longint unsigned ea;
        int e, hi, lo, bits;
        e  = int'(p[63:59]);
        hi = int'(p[58:52]);
        lo = int'(p[51:45]);
        ea = (64'(p[43:0]) + 64'(a) + 64'(b)) & 64'hFFF_FFFF_FFFF;
        bits = int'((ea >> (e + 4)) & 64'hFF);
        if (!sq) return 1'b0;
        if (e == 31) return 1'b1;
        return (bits >= 2 * lo || (hi >= lo && !p[44])) && (bits <= 2 * hi + 1 || (hi >= lo && p[44]));
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < CH; i++) begin
            p1[i] = '{0, 0, 64'd0};
            p2[i] = '{0, 0, 64'd0};
        end
        m_fv = 0; m_lane = 0; m_cnt = 0; m_fptr = '0;
    endtask

    task automatic check_outs();
        chk("out_valid", 64'(out_valid), 64'({p2[1].v, p2[0].v}));
        chk("out_ok", 64'(out_ok), 64'({p2[1].ok, p2[0].ok}));
`ifdef AGUSEC_FAULT_LOG_EN
        chk("fault_valid", 64'(fault_valid), 64'(m_fv));
        chk("fault_lane", 64'(fault_lane), 64'(m_lane));
        chk("fault_ptr", fault_ptr, m_fptr);
        chk("fault_cnt", 64'(fault_cnt), 64'(m_cnt));
`else
        chk("fault_tied", 64'(fault_valid) | 64'(fault_lane) | fault_ptr | 64'(fault_cnt), 64'd0);
`endif
    endtask

    task automatic step();
        int n;
        bit took;
        n = 0;
        took = 0;
        if (!stall) begin
            for (int i = 0; i < CH; i++)
                if (p2[i].v && !p2[i].ok) begin
                    n++;
                    if (!took && (!m_fv || fault_clr)) begin
                        m_lane = i; m_fptr = p2[i].ptr; took = 1;
                    end
                end
            m_fv  = (m_fv && !fault_clr) || n > 0;
            m_cnt = (fault_clr ? 0 : m_cnt) + n;
            if (m_cnt > 15) m_cnt = 15;
            p2 = p1;
            for (int i = 0; i < CH; i++) begin
                p1[i].v   = in_valid[i];
                p1[i].ok  = in_valid[i] && ref_ok(in_ptr[i*64 +: 64], in_a[i*40 +: 40], in_b[i*40 +: 40], in_secq[i]);
                p1[i].ptr = in_ptr[i*64 +: 64];
            end
        end
        @(posedge clk);
        #1;
        check_outs();
    endtask

    task automatic hard_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out", 64'({out_valid, out_ok}), 64'd0);
        chk("rst_fault", 64'(fault_valid) | 64'(fault_lane) | fault_ptr | 64'(fault_cnt), 64'd0);
        model_clear();
        in_valid = '0; stall = 1'b0; fault_clr = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [63:0] p, input logic [39:0] a);
        in_valid = v; in_ptr = {p, p}; in_a = {a, a}; in_b = '0; in_secq = 2'b11;
    endtask

    vec_t tv[10];
    logic [63:0] fp;
    int seen;

    initial begin
        tv[0] = '{mk(0, 'h10, 'h02, 1, 44'h0), 40'h40, 40'h0, 1, 1};
        tv[1] = '{mk(0, 'h10, 'h02, 1, 44'h0), 40'h30, 40'h0, 1, 0};
        tv[2] = '{mk(31, 'h00, 'h7f, 0, 44'h0), 40'h0, 40'h0, 0, 0};
        tv[3] = '{mk(31, 'h00, 'h7f, 0, 44'h0), 40'h0, 40'h0, 1, 1};
        tv[4] = '{mk(0, 'h10, 'h02, 0, 44'h210), 40'h0, 40'h0, 1, 1};
        tv[5] = '{mk(0, 'h10, 'h02, 0, 44'h220), 40'h0, 40'h0, 1, 0};
        tv[6] = '{mk(0, 'h10, 'h02, 1, 44'hFFF_FFFF_FFF0), 40'h50, 40'h0, 1, 1};
        tv[7] = '{mk(4, 'h10, 'h02, 1, 44'h0), 40'h300, 40'h200, 1, 1};
        tv[8] = '{mk(0, 'h10, 'h02, 0, 44'h0), 40'h30, 40'h0, 1, 1};
        tv[9] = '{mk(0, 'h10, 'h02, 1, 44'h220), 40'h0, 40'h0, 1, 1};
        model_clear();
        hard_reset();
        for (int k = 0; k < 10; k++) begin
            in_valid = 2'b01; in_ptr = {64'd0, tv[k].ptr}; in_a = {40'd0, tv[k].a};
            in_b = {40'd0, tv[k].b}; in_secq = {1'b0, tv[k].sq};
            step();
            in_valid = '0;
            step();
            chk($sformatf("vec%0d_valid", k), 64'(out_valid), 64'd1);
            chk($sformatf("vec%0d_ok", k), 64'(out_ok[0]), 64'(tv[k].ok));
        end

        fp = mk(0, 'h10, 'h02, 1, 44'h0);
        hard_reset();
        drive(2'b01, fp, 40'h30); step(); in_valid = '0; step(); step();
`ifdef AGUSEC_FAULT_LOG_EN
        chk("first_fv", 64'(fault_valid), 64'd1);
        chk("first_lane", 64'(fault_lane), 64'd0);
        chk("first_ptr", fault_ptr, fp);
        chk("first_cnt", 64'(fault_cnt), 64'd1);
`endif

        hard_reset();
        drive(2'b11, fp, 40'h30); step(); in_valid = '0; step(); step();
        drive(2'b10, fp ^ 64'h1, 40'h30); step(); in_valid = '0; step(); step();
`ifdef AGUSEC_FAULT_LOG_EN
        chk("sticky_lane", 64'(fault_lane), 64'd0);
        chk("sticky_ptr", fault_ptr, fp);
        chk("sticky_cnt", 64'(fault_cnt), 64'd3);
`endif
        drive(2'b10, fp ^ 64'h2, 40'h30); step(); in_valid = '0; step();
        fault_clr = 1'b1; step(); fault_clr = 1'b0;
`ifdef AGUSEC_FAULT_LOG_EN
        chk("clr_fv", 64'(fault_valid), 64'd1);
        chk("clr_cnt", 64'(fault_cnt), 64'd1);
        chk("clr_lane", 64'(fault_lane), 64'd1);
        chk("clr_ptr", fault_ptr, fp ^ 64'h2);
`endif

        hard_reset();
        seen = 0;
        drive(2'b01, fp, 40'h30); step(); in_valid = '0; step();
        seen += out_valid[0];
        stall = 1'b1; in_valid = 2'b11; in_a = '1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_hold_v", 64'(out_valid), 64'd1);
`ifdef AGUSEC_FAULT_LOG_EN
            chk("stall_cnt", 64'(fault_cnt), 64'd0);
`endif
        end
        stall = 1'b0; in_valid = '0;
        for (int k = 0; k < 3; k++) begin
            step();
            seen += out_valid[0];
        end
        chk("stall_results", 64'(seen), 64'd1);
`ifdef AGUSEC_FAULT_LOG_EN
        chk("stall_cnt_after", 64'(fault_cnt), 64'd1);
`endif

        hard_reset();
        drive(2'b01, fp, 40'h30);
        for (int k = 0; k < 20; k++) step();
        in_valid = '0; step(); step(); step();
`ifdef AGUSEC_FAULT_LOG_EN
        chk("sat_cnt", 64'(fault_cnt), 64'hF);
`endif

        drive(2'b11, mk(0, 'h10, 'h02, 1, 44'h0), 40'h40); step();
        in_valid = '0;
        #2;
        hard_reset();
        for (int k = 0; k < 3; k++) begin
            step();
            chk("no_ghost", 64'(out_valid), 64'd0);
        end

        for (int k = 0; k < 2000; k++) begin
            stall = ($urandom_range(0, 3) == 0);
            fault_clr = ($urandom_range(0, 7) == 0);
            in_valid = 2'($urandom);
            for (int i = 0; i < CH; i++) begin
                in_ptr[i*64 +: 64] = {$urandom, $urandom};
                if ($urandom_range(0, 1) == 1) in_ptr[i*64 + 59 +: 5] = 5'($urandom_range(0, 3));
                in_a[i*40 +: 40] = 40'({$urandom, $urandom});
                in_b[i*40 +: 40] = 40'($urandom_range(0, 255));
                in_secq[i] = ($urandom_range(0, 7) != 0);
            end
            step();
        end
        stall = 1'b0; fault_clr = 1'b0; in_valid = '0;
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/agusec_check_pipe.md
AGUSEC_CHECK_PIPE -- requirements
Module: agusec_check_pipe

Interface
REQ-001 SHALL take parameter CHANNELS, default 2, giving the number of independent check lanes (1..8).
REQ-002 SHALL take parameter CNT_W, default 16, giving the fault counter width (>=4).
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port stall, input, 1: freezes every pipeline register when high.
REQ-006 SHALL have port in_valid, input, CHANNELS: per-lane request valid.
REQ-007 SHALL have port in_ptr, input, 64*CHANNELS: per-lane bounded pointer.
REQ-008 SHALL have port in_a and port in_b, input, 40*CHANNELS each: per-lane address addends.
REQ-009 SHALL have port in_secq, input, CHANNELS: per-lane incoming security-ok bit.
REQ-010 SHALL have port out_valid and port out_ok, output, CHANNELS each: per-lane result.
REQ-011 SHALL have ports fault_valid (1), fault_lane (3), fault_ptr (64) and fault_cnt (CNT_W), all outputs; fault_clr SHALL be a 1-bit input.

Function
REQ-012 SHALL decode ptr fields as: exp=ptr[63:59], hi=ptr[58:52], low=ptr[51:45], on_low=ptr[44], addr=ptr[43:0].
REQ-013 Stage 1 SHALL compute eaddr = addr + zext(a) + zext(b) mod 2^44, then bits[7:0] = eaddr[exp+4 +: 8], zero-filling positions above 43, and register bits, the fields and secq.
REQ-014 Stage 2 SHALL set low8={low,0}, high8={hi,1} and diff=(hi>=low), all unsigned.
REQ-015 Stage 2 SHALL compute ok = secq && (bits>=low8 || diff&&~on_low) && (bits<=high8 || diff&&on_low).
REQ-016 When exp==31, ok SHALL equal secq.
REQ-017 Latency SHALL be 2 clk edges from in_valid to out_valid with no stall; throughput one request per lane per cycle.
REQ-018 While stall=1, stage registers and outputs SHALL hold; inputs presented during stall SHALL be ignored.
REQ-019 out_ok SHALL be 0 whenever out_valid=0 for that lane.
REQ-020 A lane faults in a cycle when out_valid=1 and out_ok=0; lanes SHALL be processed independently.
REQ-021 On a fault while fault_valid=0, the block SHALL capture the lowest-indexed faulting lane into fault_lane, capture its pointer into fault_ptr, and set fault_valid=1 on the next edge.
REQ-022 While fault_valid=1, further faults SHALL NOT overwrite fault_lane or fault_ptr (first fault is sticky).
REQ-023 fault_cnt SHALL add the number of faulting lanes each cycle and saturate at all-ones.
REQ-024 fault_clr=1 SHALL clear fault_valid and fault_cnt; on a simultaneous fault, the block SHALL capture the new fault and load the counter with that cycle's fault count.
REQ-025 Fault logic SHALL advance only on cycles with stall=0.

Reset
REQ-026 rst_n low SHALL immediately clear all valid bits, out_ok, fault_valid, fault_lane, fault_ptr and fault_cnt, independent of clk.
REQ-027 An in-flight request during reset SHALL be discarded; the first valid output after release SHALL appear 2 edges after a post-reset request.

Configuration
REQ-028 Macro AGUSEC_FAULT_LOG_EN defined SHALL compile in the fault capture and counter logic of REQ-020..025.
REQ-029 With AGUSEC_FAULT_LOG_EN undefined, fault_valid, fault_lane, fault_ptr and fault_cnt SHALL be constant 0, fault_clr SHALL be ignored, and the check path SHALL be unchanged.

Verification
REQ-030 Lane0: exp=0, low=7'h02, hi=7'h10, on_low=1, addr=0, a=0x40, b=0, secq=1 -> out_ok=1 two cycles later (bits=0x04).
REQ-031 Same lane0 with a=0x30 -> out_ok=0, fault_valid=1, fault_lane=0, fault_ptr=in_ptr, fault_cnt=1.
REQ-032 Both lanes fault in one cycle, then lane1 faults again -> fault_lane=0 retained, fault_cnt=3; fault_clr together with a single fault -> fault_valid=1, fault_cnt=1.
REQ-033 stall=1 for 3 cycles mid-flight -> outputs hold, no duplicate or lost result, fault_cnt unchanged during stall.
REQ-034 With CNT_W=4, 20 consecutive single-lane faults -> fault_cnt=4'hF; exp=31 with secq=0 -> out_ok=0, with secq=1 -> out_ok=1.
REQ-035 rst_n asserted with a request in stage 1 -> all outputs 0 immediately, no out_valid after release.
